// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants,
// common to the uart_tx and uart_rx_parity stages.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int START_MID  = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_rx_parity_if.sv
// Consumer-side bundle of the UART receiver: received byte, done pulse, error flags.
interface uart_rx_parity_if;

  logic [7:0] dout;
  logic       rx_done_tick;
  logic       parity_err;
  logic       frame_err;

  modport master (output dout, rx_done_tick, parity_err, frame_err);
  modport slave  (input  dout, rx_done_tick, parity_err, frame_err);

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level (1).
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_parity.sv
// Oversampling UART receiver (16 s_tick per bit) with optional parity and
// framing-error detection; result presented with a one-cycle done pulse.
module uart_rx_parity
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  input  logic s_tick,
  uart_rx_parity_if.master rx_if
);

  localparam logic [4:0] MID_TICK  = 5'(START_MID);
  localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
  localparam logic       PAR_INIT  = 1'(PARITY_ODD);

  logic        rx_s;
  uart_state_t state;
  logic [4:0]  s;
  logic [2:0]  n;
  logic [7:0]  b;
  logic        par;
  logic        perr_next;
  logic        need_high;

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      s                  <= '0;
      n                  <= '0;
      b                  <= '0;
      par                <= 1'b0;
      perr_next          <= 1'b0;
      need_high          <= 1'b0;
      rx_if.dout         <= '0;
      rx_if.rx_done_tick <= 1'b0;
      rx_if.parity_err   <= 1'b0;
      rx_if.frame_err    <= 1'b0;
    end else begin
      rx_if.rx_done_tick <= 1'b0;
      case (state)
        // After a low stop bit the line may still be in break; wait for a 1
        // before treating a low level as a new start bit.
        IDLE: begin
          if (need_high) begin
            if (rx_s) need_high <= 1'b0;
          end else if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == MID_TICK) begin
              s <= '0;
              if (!rx_s) begin
                state <= DATA;
                n     <= '0;
                par   <= PAR_INIT;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == BIT_LAST) begin
              b   <= {rx_s, b[7:1]};
              par <= par ^ rx_s;
              s   <= '0;
              if (n == N_LAST) state <= (PARITY_EN != 0) ? PARITY : STOP;
              else             n     <= n + 3'd1;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        PARITY: begin
          if (s_tick) begin
            if (s == BIT_LAST) begin
              perr_next <= par ^ rx_s;
              s         <= '0;
              state     <= STOP;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == STOP_LAST) begin
              rx_if.frame_err    <= ~rx_s;
              rx_if.parity_err   <= (PARITY_EN != 0) ? perr_next : 1'b0;
              rx_if.dout         <= b >> (8 - DBIT);
              rx_if.rx_done_tick <= 1'b1;
              need_high          <= ~rx_s;
              s                  <= '0;
              state              <= IDLE;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          s     <= '0;
          n     <= '0;
        end
      endcase
    end
  end

endmodule
